// File: rtl/oam_dma_pkg.sv
// Shared definitions for the OAM DMA engine: video host register indices,
// the trigger address and the transfer state encoding.
package oam_dma_pkg;

  localparam logic [2:0] REG_CONTROL  = 3'd0;
  localparam logic [2:0] REG_MASK     = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_OAM_ADDR = 3'd3;
  localparam logic [2:0] REG_OAM_DATA = 3'd4;
  localparam logic [2:0] REG_SCROLL   = 3'd5;
  localparam logic [2:0] REG_PPU_ADDR = 3'd6;
  localparam logic [2:0] REG_PPU_DATA = 3'd7;

  localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// Bus bundle between the DMA engine and its surroundings: CPU snoop/halt,
// CPU memory read port and video host write port.
//
// Handshake: there is no valid/ready pair. Every transfer step is qualified by
// I_cpu_ce; a read is O_mem_rden held for a CPU cycle with I_mem_data sampled at
// its I_cpu_ce edge, a host write is O_host_wren high in exactly one I_clock
// (the one carrying I_cpu_ce) of a WRITE cycle.
interface oam_dma_if;
  logic        I_cpu_ce;
  logic [15:0] I_cpu_addr;
  logic        I_cpu_wren;
  logic [7:0]  I_cpu_data;
  logic        O_cpu_halt;
  logic [15:0] O_mem_addr;
  logic        O_mem_rden;
  logic [7:0]  I_mem_data;
  logic [2:0]  O_host_addr;
  logic        O_host_wren;
  logic [7:0]  O_host_data;
  logic        O_busy;

  modport master (
    input  I_cpu_ce, I_cpu_addr, I_cpu_wren, I_cpu_data, I_mem_data,
    output O_cpu_halt, O_mem_addr, O_mem_rden, O_host_addr, O_host_wren,
           O_host_data, O_busy
  );

  modport slave (
    output I_cpu_ce, I_cpu_addr, I_cpu_wren, I_cpu_data, I_mem_data,
    input  O_cpu_halt, O_mem_addr, O_mem_rden, O_host_addr, O_host_wren,
           O_host_data, O_busy
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA initiator: snoops the trigger write, halts the CPU and copies one
// 256-byte CPU page into OAMDATA using alternating get/put CPU cycles.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR  = DMA_TRIGGER_ADDR,
  parameter logic [2:0]  OAMDATA_INDEX = REG_OAM_DATA
) (
  input  logic       I_clock,
  input  logic       I_reset,
  oam_dma_if.master  bus,
  output dma_state_t O_state
);

  dma_state_t state_q, state_d;
  logic       parity_q, parity_d;
  logic [7:0] index_q, index_d;
  logic [7:0] page_q, page_d;
  logic [7:0] data_q, data_d;
  logic       trigger;

  assign trigger = bus.I_cpu_wren && (bus.I_cpu_addr == TRIGGER_ADDR);

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      index_q  <= 8'h00;
      page_q   <= 8'h00;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      index_q  <= index_d;
      page_q   <= page_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    parity_d = parity_q ^ bus.I_cpu_ce;
    index_d  = index_q;
    page_d   = page_q;
    data_d   = data_q;
    if (bus.I_cpu_ce) begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            page_d  = bus.I_cpu_data;
            index_d = 8'h00;
            state_d = HALT;
          end
        end
        // parity_q is this cycle's parity; the following cycle is a get cycle
        // when it is 1, so reads can start immediately without realignment.
        HALT:  state_d = parity_q ? READ : ALIGN;
        ALIGN: state_d = READ;
        READ: begin
          data_d  = bus.I_mem_data;
          state_d = WRITE;
        end
        WRITE: begin
          index_d = index_q + 8'h01;
          state_d = (index_q == 8'hFF) ? IDLE : READ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.O_busy      = (state_q != IDLE);
  assign bus.O_cpu_halt  = (state_q != IDLE);
  assign bus.O_mem_rden  = (state_q == READ);
  assign bus.O_mem_addr  = (state_q == READ) ? {page_q, index_q} : 16'h0000;
  assign bus.O_host_addr = (state_q != IDLE) ? OAMDATA_INDEX : 3'd0;
  assign bus.O_host_data = (state_q == WRITE) ? data_q : 8'h00;
  // One strobe per byte even when CPU cycles span several clocks.
  assign bus.O_host_wren = (state_q == WRITE) && bus.I_cpu_ce;
  assign O_state         = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// Randomized scoreboard bench for oam_dma: expected OAM bytes, read addresses
// and halt lengths are queued at trigger time and checked by a monitor.
module tb_oam_dma;
  import oam_dma_pkg::*;

  logic       clk;
  logic       rst_n;
  dma_state_t dbg_state;
  oam_dma_if  bus();

  oam_dma #(.TRIGGER_ADDR(16'h4014), .OAMDATA_INDEX(3'd4)) dut (
    .I_clock(clk),
    .I_reset(rst_n),
    .bus(bus),
    .O_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] addr_q[$];
  logic [31:0] len_q[$];

  logic [7:0] mem_salt = 8'h58;
  int         ce_div   = 1;
  int         ce_phase = 0;
  int         ce_cnt   = 0;
  int         halt_cnt = 0;
  int         wr_cnt   = 0;
  logic       busy_prev = 1'b0;

  // Reference memory: byte = low address ^ page ^ salt.
  assign bus.I_mem_data = bus.O_mem_addr[7:0] ^ bus.O_mem_addr[15:8] ^ mem_salt;

  // ---------------- clock / reset / CPU cycle enable ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) ce_cnt = 0;
    else if (bus.I_cpu_ce) ce_cnt++;
    #1;
    ce_phase = (ce_phase + 1 >= ce_div) ? 0 : ce_phase + 1;
    bus.I_cpu_ce = (ce_phase == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      halt_cnt  = 0;
      wr_cnt    = 0;
      busy_prev = 1'b0;
    end else begin
      chk("halt_eq_busy", {31'd0, bus.O_cpu_halt}, {31'd0, bus.O_busy});
      if (bus.O_busy && !busy_prev) begin
        halt_cnt = 0;
        wr_cnt   = 0;
      end
      if (bus.O_busy && bus.I_cpu_ce) halt_cnt++;
      if (bus.O_host_wren) begin
        chk("wren_with_ce", {31'd0, bus.I_cpu_ce}, 32'd1);
        chk("host_addr", {29'd0, bus.O_host_addr}, 32'd4);
        if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else chk("host_data", {24'd0, bus.O_host_data}, {24'd0, exp_q.pop_front()});
        wr_cnt++;
      end
      if (bus.O_mem_rden && bus.I_cpu_ce) begin
        if (addr_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else chk("mem_addr", {16'd0, bus.O_mem_addr}, {16'd0, addr_q.pop_front()});
      end
      if (!bus.O_busy) begin
        chk("idle_outputs", {bus.O_mem_addr, 7'd0, bus.O_mem_rden, 5'd0,
                             bus.O_host_addr, bus.O_host_data}, 32'd0);
        chk("idle_wren", {31'd0, bus.O_host_wren}, 32'd0);
        if (busy_prev) begin
          if (len_q.size() == 0) chk("unexpected_transfer", 32'd1, 32'd0);
          else chk("halt_length", halt_cnt, len_q.pop_front());
          chk("writes_left", exp_q.size(), 32'd0);
          chk("reads_left", addr_q.size(), 32'd0);
          chk("write_count", wr_cnt, 32'd256);
        end
      end
      busy_prev = bus.O_busy;
    end
  end

  // ---------------- drivers ----------------
  // want_par: parity of the cycle following the trigger edge (1 = next is get),
  // or -1 for whatever comes first.
  task automatic trigger(input logic [7:0] page, input int want_par);
    int n = 0;
    int halt_par;
    forever begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        chk("trigger_timeout", 32'd1, 32'd0);
        return;
      end
      if (bus.I_cpu_ce && !bus.O_busy &&
          (want_par < 0 || ((ce_cnt + 1) % 2) == want_par)) break;
    end
    halt_par = (ce_cnt + 1) % 2;
    for (int i = 0; i < 256; i++) begin
      addr_q.push_back({page, i[7:0]});
      exp_q.push_back(i[7:0] ^ page ^ mem_salt);
    end
    len_q.push_back(halt_par == 1 ? 32'd513 : 32'd514);
    bus.I_cpu_addr = 16'h4014;
    bus.I_cpu_data = page;
    bus.I_cpu_wren = 1'b1;
    @(posedge clk);
    #1;
    bus.I_cpu_wren = 1'b0;
  endtask

  task automatic raw_write(input logic [15:0] addr, input logic [7:0] data);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.I_cpu_ce && n < 20);
    bus.I_cpu_addr = addr;
    bus.I_cpu_data = data;
    bus.I_cpu_wren = 1'b1;
    @(posedge clk);
    #1;
    bus.I_cpu_wren = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.O_busy) begin
      @(negedge clk);
      n++;
      if (n > 514 * 4 * ce_div + 100) begin
        chk("idle_timeout", 32'd1, 32'd0);
        return;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_writes(input int cnt);
    int n = 0;
    forever begin
      @(negedge clk);
      #1;
      n++;
      if (wr_cnt == cnt && bus.O_busy) return;
      if (n > 514 * 4 * ce_div + 100) begin
        chk("write_wait_timeout", 32'd1, 32'd0);
        return;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.I_cpu_ce   = 1'b0;
    bus.I_cpu_addr = 16'h0000;
    bus.I_cpu_wren = 1'b0;
    bus.I_cpu_data = 8'h00;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_state", {29'd0, dbg_state}, {29'd0, IDLE});
    chk("reset_halt", {31'd0, bus.O_cpu_halt}, 32'd0);
    chk("reset_outputs", {bus.O_mem_addr, 7'd0, bus.O_mem_rden, 5'd0,
                          bus.O_host_addr, bus.O_host_data}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Non-trigger write must not start a transfer.
    raw_write(16'h4013, 8'h02);
    repeat (4) @(negedge clk);
    chk("no_start_other_addr", {31'd0, bus.O_busy}, 32'd0);

    // Page 02, bytes 5A,5B,...; with and without the ALIGN cycle.
    mem_salt = 8'h58;
    trigger(8'h02, 1);
    wait_idle();
    trigger(8'h02, 0);
    wait_idle();

    // Slow CPU cycles.
    ce_div = 3;
    trigger(8'h02, -1);
    wait_idle();

    // Top page must not wrap into page 00.
    ce_div = 1;
    mem_salt = 8'($urandom);
    trigger(8'hFF, $urandom_range(0, 1));
    wait_idle();
    chk("ff_returns_idle", {29'd0, dbg_state}, {29'd0, IDLE});

    // Trigger during transfer is ignored.
    trigger(8'h10, $urandom_range(0, 1));
    wait_writes(50);
    raw_write(16'h4014, 8'h07);
    wait_idle();

    // Trigger in the final WRITE cycle is ignored.
    ce_div = 2;
    trigger(8'h20, -1);
    wait_writes(256);
    bus.I_cpu_addr = 16'h4014;
    bus.I_cpu_data = 8'h33;
    bus.I_cpu_wren = 1'b1;
    @(posedge clk);
    #1;
    bus.I_cpu_wren = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    chk("last_write_trigger_ignored", {31'd0, bus.O_busy}, 32'd0);

    // Reset after byte 100.
    ce_div = 1;
    trigger(8'h44, -1);
    wait_writes(100);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_halt", {31'd0, bus.O_cpu_halt}, 32'd0);
    chk("rst_busy", {31'd0, bus.O_busy}, 32'd0);
    chk("rst_outputs", {bus.O_mem_addr, 7'd0, bus.O_mem_rden, 5'd0,
                        bus.O_host_addr, bus.O_host_data}, 32'd0);
    chk("rst_wren", {31'd0, bus.O_host_wren}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    exp_q.delete();
    addr_q.delete();
    len_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    trigger(8'h45, -1);
    wait_idle();

    // Random transfers.
    for (int k = 0; k < 5; k++) begin
      ce_div   = $urandom_range(1, 3);
      mem_salt = 8'($urandom);
      trigger(8'($urandom), $urandom_range(0, 1));
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
